// File: rtl/mem_arbiter.sv
// Byte-wide memory port arbiter: instruction-fetch word reads vs load/store byte/half/word accesses.
// Define MEM_ARB_FLUSH_EN to add flush_in, which aborts an in-flight fetch.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int IO_SEL_HI  = 17
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_done,
  output logic [31:0]           if_data,
  input  logic                  ls_req,
  input  logic                  ls_wr,
  input  logic [1:0]            ls_size,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [31:0]           ls_wdata,
  output logic                  ls_done,
  output logic [31:0]           ls_rdata,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
`ifdef MEM_ARB_FLUSH_EN
  input  logic                  flush_in,
`endif
  input  logic                  io_buffer_full
);

  // IDLE: arbitrate | RD: issue/capture read bytes | WR: issue write bytes
  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

  state_t                state, state_nx;
  logic                  grant_ls, last_ls, pend;
  logic [2:0]            len, iss, rcv, ls_len;
  logic [ADDR_WIDTH-1:0] base, cur_addr;
  logic [31:0]           wdata, rbuf, rd_word;
  logic                  flush, if_ok, ls_ok, is_io;
  logic                  take_if, take_ls, issue, capture, finish, rewind;

`ifdef MEM_ARB_FLUSH_EN
  assign flush = flush_in;
`else
  assign flush = 1'b0;
`endif

  assign cur_addr = base + {{(ADDR_WIDTH-3){1'b0}}, iss};
  assign is_io    = (cur_addr[IO_SEL_HI -: 2] == 2'b11);
  assign if_ok    = if_req && !if_done && !flush;
  assign ls_ok    = ls_req && !ls_done;
  assign ls_len   = (ls_size == 2'd0) ? 3'd1 : (ls_size == 2'd1) ? 3'd2 : 3'd4;
  assign rewind   = (state == S_RD) && !rdy_in;

  always_comb begin
    rd_word = rbuf;
    rd_word[8*rcv[1:0] +: 8] = mem_din;
  end

  always_comb begin
    state_nx = state;
    take_if  = 1'b0;
    take_ls  = 1'b0;
    issue    = 1'b0;
    capture  = 1'b0;
    finish   = 1'b0;
    mem_a    = '0;
    mem_dout = 8'h00;
    mem_wr   = 1'b0;
    case (state)
      S_IDLE: begin
        if (rdy_in) begin
          if (if_ok && (!ls_ok || last_ls)) take_if = 1'b1;
          else if (ls_ok)                   take_ls = 1'b1;
          if (take_if || (take_ls && !ls_wr)) state_nx = S_RD;
          else if (take_ls)                   state_nx = S_WR;
        end
      end
      S_RD: begin
        if (flush && !grant_ls) begin
          state_nx = S_IDLE;
        end else if (rdy_in) begin
          issue   = (iss < len);
          capture = pend;
          if (pend && (rcv + 3'd1 == len)) begin
            finish   = 1'b1;
            state_nx = S_IDLE;
          end
        end
      end
      S_WR: begin
        // I/O writes wait for room in the UART transmit buffer
        if (rdy_in && !(is_io && io_buffer_full)) begin
          issue    = 1'b1;
          mem_wr   = 1'b1;
          mem_dout = wdata[8*iss[1:0] +: 8];
          if (iss + 3'd1 == len) begin
            finish   = 1'b1;
            state_nx = S_IDLE;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
    if (issue) mem_a = cur_addr;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state    <= S_IDLE;
      grant_ls <= 1'b0;
      last_ls  <= 1'b1;
      pend     <= 1'b0;
      len      <= 3'd0;
      iss      <= 3'd0;
      rcv      <= 3'd0;
      base     <= '0;
      wdata    <= 32'h0;
      rbuf     <= 32'h0;
      if_done  <= 1'b0;
      ls_done  <= 1'b0;
      if_data  <= 32'h0;
      ls_rdata <= 32'h0;
    end else begin
      state   <= state_nx;
      if_done <= finish && !grant_ls;
      ls_done <= finish && grant_ls;
      pend    <= issue && (state == S_RD);
      if (take_if || take_ls) begin
        grant_ls <= take_ls;
        last_ls  <= take_ls;
        base     <= take_ls ? ls_addr : if_addr;
        len      <= take_ls ? ls_len : 3'd4;
        wdata    <= ls_wdata;
        iss      <= 3'd0;
        rcv      <= 3'd0;
        rbuf     <= 32'h0;
      end else begin
        // a paused bus loses the read in flight, so reissue from the first uncaptured byte
        if (rewind)     iss <= rcv;
        else if (issue) iss <= iss + 3'd1;
        if (capture) begin
          rbuf <= rd_word;
          rcv  <= rcv + 3'd1;
        end
      end
      if (finish && (state == S_RD)) begin
        if (grant_ls) ls_rdata <= rd_word;
        else          if_data  <= rd_word;
      end
    end
  end

endmodule
